// File: rtl/vote_filter.sv
// N-input majority/minority voter with a two-stage pipeline and a HOLD-sample
// debounce filter on the voted result.
module vote_filter #(
  parameter  int N    = 3,
  parameter  int HOLD = 3,
  localparam int CW   = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [N-1:0]  a,
  input  logic          mode,
  output logic          y,
  output logic          y_valid,
  output logic [CW-1:0] count,
  output logic          changed
);

  localparam int HW = $clog2(HOLD + 1);

  if ((N < 3) || ((N % 2) == 0)) begin : g_bad_n
    $error("vote_filter: N must be odd and >= 3");
  end
  if (HOLD < 1) begin : g_bad_hold
    $error("vote_filter: HOLD must be >= 1");
  end

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = CW'(0);
    for (int i = 0; i < N; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  logic [CW-1:0] pc_s;
  logic          s1_valid_r;
  logic          s1_raw_r;
  logic [CW-1:0] s1_count_r;
  state_t        state_r;
  logic [HW-1:0] cnt_r;

  // popcount of the incoming sample
  always_comb begin
    pc_s = popcount(a);
  end

  // stage 1: register popcount and the raw vote; minority is the complement for odd N
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_raw_r   <= 1'b0;
      s1_count_r <= CW'(0);
    end else begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_count_r <= pc_s;
        s1_raw_r   <= (pc_s > CW'(N / 2)) ^ mode;
      end else begin
        s1_count_r <= s1_count_r;
        s1_raw_r   <= s1_raw_r;
      end
    end
  end

  // stage 2: debounce filter and registered outputs, advancing only on processed samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= STABLE;
      cnt_r   <= HW'(0);
      y       <= 1'b0;
      y_valid <= 1'b0;
      changed <= 1'b0;
      count   <= CW'(0);
    end else begin
      y_valid <= s1_valid_r;
      changed <= 1'b0;
      if (s1_valid_r) begin
        count <= s1_count_r;
        case (state_r)
          STABLE: begin
            if (s1_raw_r == y) begin
              cnt_r <= HW'(0);
            end else if (HOLD == 1) begin
              y       <= s1_raw_r;
              changed <= 1'b1;
              cnt_r   <= HW'(0);
            end else begin
              state_r <= PENDING;
              cnt_r   <= HW'(1);
            end
          end
          PENDING: begin
            if (s1_raw_r == y) begin
              state_r <= STABLE;
              cnt_r   <= HW'(0);
            end else if ((cnt_r + HW'(1)) == HW'(HOLD)) begin
              y       <= s1_raw_r;
              changed <= 1'b1;
              cnt_r   <= HW'(0);
              state_r <= STABLE;
            end else begin
              cnt_r <= cnt_r + HW'(1);
            end
          end
          default: begin
            state_r <= STABLE;
            cnt_r   <= HW'(0);
          end
        endcase
      end else begin
        state_r <= state_r;
        cnt_r   <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_vote_filter.sv
// Bench for vote_filter: three instances (N3/HOLD3, N3/HOLD1, N5/HOLD3) driven in
// lockstep and compared against a streak-based reference of the voting rules.
module tb_vote_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] a3 = 3'b000;
  logic [4:0] a5 = 5'b00000;

  logic       y_w  [3];
  logic       yv_w [3];
  logic       ch_w [3];
  logic [1:0] cnt0;
  logic [1:0] cnt1;
  logic [2:0] cnt2;

  vote_filter #(.N(3), .HOLD(3)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a3), .mode(mode),
    .y(y_w[0]), .y_valid(yv_w[0]), .count(cnt0), .changed(ch_w[0]));
  vote_filter #(.N(3), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a3), .mode(mode),
    .y(y_w[1]), .y_valid(yv_w[1]), .count(cnt1), .changed(ch_w[1]));
  vote_filter #(.N(5), .HOLD(3)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a5), .mode(mode),
    .y(y_w[2]), .y_valid(yv_w[2]), .count(cnt2), .changed(ch_w[2]));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: voted output, run of disagreeing samples, pending output
  int nn [3] = '{3, 3, 5};
  int hh [3] = '{3, 1, 3};
  int ref_y    [3];
  int streak   [3];
  int pend_cnt [3];
  int pend_chg [3];
  int exp_cnt  [3];
  int pend_v;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ones(input logic [4:0] x, input int n);
    int c = 0;
    for (int b = 0; b < n; b++) c += int'(x[b]);
    return c;
  endfunction

  task automatic check_outputs();
    int c;
    for (int i = 0; i < 3; i++) begin
      if (pend_v != 0) exp_cnt[i] = pend_cnt[i];
      c = (i == 0) ? int'(cnt0) : (i == 1) ? int'(cnt1) : int'(cnt2);
      chk($sformatf("y_valid[%0d]", i), int'(yv_w[i]), pend_v);
      chk($sformatf("y[%0d]", i), int'(y_w[i]), ref_y[i]);
      chk($sformatf("changed[%0d]", i), int'(ch_w[i]), (pend_v != 0) ? pend_chg[i] : 0);
      chk($sformatf("count[%0d]", i), c, exp_cnt[i]);
    end
  endtask

  task automatic model_reset();
    pend_v = 0;
    for (int i = 0; i < 3; i++) begin
      ref_y[i] = 0; streak[i] = 0; pend_cnt[i] = 0; pend_chg[i] = 0; exp_cnt[i] = 0;
    end
  endtask

  // one clock: present inputs, check what the previous sample produced, then feed the model
  task automatic step(input logic v, input logic [2:0] x3, input logic [4:0] x5, input logic m);
    int k;
    int raw;
    in_valid = v; a3 = x3; a5 = x5; mode = m;
    @(posedge clk); #1;
    check_outputs();
    pend_v = int'(v);
    for (int i = 0; i < 3; i++) begin
      pend_chg[i] = 0;
      if (v) begin
        k = (i == 2) ? ones(x5, 5) : ones({2'b00, x3}, 3);
        pend_cnt[i] = k;
        raw = ((2 * k > nn[i]) ? 1 : 0) ^ int'(m);
        if (raw != ref_y[i]) begin
          streak[i]++;
          if (streak[i] >= hh[i]) begin
            ref_y[i] = raw; pend_chg[i] = 1; streak[i] = 0;
          end
        end else begin
          streak[i] = 0;
        end
      end
    end
  endtask

  // async reset applied between edges; outputs must clear before any clock
  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk); #1;
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // exhaustive patterns, majority mode, back to back
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 5'(i), 1'b0);
    step(1'b0, 3'b000, 5'b00000, 1'b0);
    step(1'b0, 3'b000, 5'b00000, 1'b0);

    // debounce: three agreeing samples flip the HOLD=3 output
    do_reset();
    repeat (3) step(1'b1, 3'b111, 5'b11111, 1'b0);
    repeat (2) step(1'b0, 3'b000, 5'b00000, 1'b0);

    // glitch in the middle of a streak
    do_reset();
    step(1'b1, 3'b111, 5'b11111, 1'b0);
    step(1'b1, 3'b111, 5'b11111, 1'b0);
    step(1'b1, 3'b000, 5'b00000, 1'b0);
    step(1'b1, 3'b111, 5'b11111, 1'b0);
    step(1'b1, 3'b111, 5'b11111, 1'b0);
    repeat (2) step(1'b0, 3'b000, 5'b00000, 1'b0);

    // gaps in in_valid do not reset the streak
    do_reset();
    repeat (3) begin
      step(1'b1, 3'b111, 5'b11111, 1'b0);
      repeat (2) step(1'b0, 3'b000, 5'b00000, 1'b0);
    end
    step(1'b0, 3'b000, 5'b00000, 1'b0);

    // minority then majority with a constant input
    do_reset();
    repeat (3) step(1'b1, 3'b001, 5'b00001, 1'b1);
    repeat (3) step(1'b1, 3'b001, 5'b00001, 1'b0);
    repeat (2) step(1'b0, 3'b000, 5'b00000, 1'b0);

    // reset mid-streak with a sample still in stage 1
    do_reset();
    step(1'b1, 3'b111, 5'b11111, 1'b0);
    step(1'b1, 3'b111, 5'b11111, 1'b0);
    step(1'b1, 3'b111, 5'b11111, 1'b0);
    do_reset();
    step(1'b1, 3'b111, 5'b11111, 1'b0);
    step(1'b1, 3'b111, 5'b11111, 1'b0);
    repeat (2) step(1'b0, 3'b000, 5'b00000, 1'b0);

    // N=5 three-of-five sample
    step(1'b1, 3'b011, 5'b00111, 1'b0);
    step(1'b0, 3'b000, 5'b00000, 1'b0);

    // randomized traffic
    do_reset();
    for (int t = 0; t < 300; t++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), 5'($urandom), 1'($urandom_range(0, 7) == 0));
    end
    repeat (2) step(1'b0, 3'b000, 5'b00000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vote_filter.md
VOTE_FILTER -- requirements
Module: vote_filter

Interface
REQ-001 Parameter N, default 3: number of voter inputs; odd, >= 3; elaboration SHALL fail otherwise.
REQ-002 Parameter HOLD, default 3: consecutive agreeing samples required before the output changes; >= 1; elaboration SHALL fail otherwise.
REQ-003 Parameter CW = $clog2(N+1) (derived, not overridable): width of the count output.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 in_valid  in  1  qualifies a, mode this cycle.
REQ-007 a  in  N  voter inputs, one bit per channel.
REQ-008 mode  in  1  0 = majority vote, 1 = minority vote; sampled with a.
REQ-009 y  out  1  filtered vote result.
REQ-010 y_valid  out  1  one-cycle pulse per processed sample.
REQ-011 count  out  CW  number of ones in the processed sample, aligned with y_valid.
REQ-012 changed  out  1  one-cycle pulse when y toggles.

Function
REQ-013 Stage 1 SHALL, on an edge with in_valid=1, register popcount(a) and raw = (popcount(a) > N/2) XOR mode, and set s1_valid; s1_valid SHALL be 0 after any edge with in_valid=0.
- minority is the exact complement of majority for odd N.
REQ-014 Stage 2 SHALL update the filter and the outputs only on edges where s1_valid=1; filter state SHALL hold otherwise.
REQ-015 y_valid SHALL be 1 for exactly the cycle after each stage-2 update; count SHALL show that sample's popcount during that cycle and hold it afterwards.
REQ-016 Latency: a sample accepted at edge k SHALL produce y_valid=1 after edge k+1.
REQ-017 The filter SHALL have two states, STABLE and PENDING, with a stability counter of width $clog2(HOLD+1).
REQ-018 In STABLE, raw == y: stay in STABLE, counter = 0.
REQ-019 In STABLE, raw != y and HOLD = 1: y <= raw, changed pulse, stay in STABLE.
REQ-020 In STABLE, raw != y and HOLD > 1: go to PENDING, counter = 1.
REQ-021 In PENDING, raw == y: go to STABLE, counter = 0; no output change.
REQ-022 In PENDING, raw != y and counter+1 == HOLD: y <= raw, changed pulse, counter = 0, go to STABLE.
REQ-023 In PENDING, raw != y and counter+1 < HOLD: counter increments.
REQ-024 Gaps in in_valid SHALL NOT reset the counter; only processed samples count toward HOLD.
REQ-025 A mode change between samples SHALL apply only to samples carrying the new mode value.
- A flip of raw caused only by mode SHALL be filtered like any other flip.
REQ-026 changed SHALL coincide with the y_valid pulse of the sample that caused the toggle; it SHALL never be asserted without y_valid.
REQ-027 The counter SHALL never exceed HOLD-1; it SHALL not wrap.

Reset
REQ-028 While rst=1, and immediately on its assertion (independent of clk), the following SHALL be forced: y=0, y_valid=0, changed=0, count=0, s1_valid=0, counter=0, state=STABLE.
REQ-029 Reset asserted mid-PENDING SHALL discard the partial count; a sample in stage 1 SHALL be dropped with no y_valid.
REQ-030 The first sample accepted on the first edge after rst falls SHALL be processed normally.

Verification (N=3, HOLD=3 unless stated)
REQ-031 Exhaustive mode=0, HOLD=1: each of a=0..7 gives y = majority(a) two edges later; count = popcount.
REQ-032 Debounce: y=0, then a=3'b111 for three consecutive valid samples -> y stays 0 after samples 1 and 2; y=1 and changed=1 after sample 3's y_valid.
REQ-033 Glitch: y=0, then samples 111, 111, 000, 111, 111 -> y never toggles and changed never pulses.
REQ-034 Gapped valid: three 111 samples separated by 2 idle cycles each -> y=1 after the third sample's y_valid.
REQ-035 Mode: y=0, constant a=3'b001, mode=1 for three samples -> y=1; then mode=0 for three samples -> y=0.
REQ-036 Reset mid-PENDING after two 111 samples, then two 111 samples after release -> y stays 0; N=5 scenario: a=5'b00111 -> count=3, majority=1.
